// File: rtl/updown_sweep_controller_if.sv
// ---------------------------------------------------------------------------
// updown_sweep_controller_if
//
// Bundles the host-side control inputs and the sweep status outputs of the
// up/down sweep controller.
//
// Handshake: start is a level request sampled only while busy=0. A request
// is accepted on the clock edge that samples it with abort=0 and legal
// bounds. busy=1 is visible from the next cycle. A request with bad bounds
// produces a single-cycle err instead. done is a single-cycle pulse that
// coincides with the first cycle of busy=0 after a normal completion. A new
// start may be presented on that same cycle.
//
// Signals
//   start, abort, pause        host -> controller control
//   lo, hi, passes             sweep program, latched on an accepted start
//   count, direction           counter value and counting direction
//   busy, done, err            status / handshake responses
//   passes_left                passes remaining, including the current pass
//   dbg_state                  FSM state (0 = IDLE, 1 = UP, 2 = DOWN)
//
// Modports
//   master : host side (drives the controls, observes the status)
//   slave  : controller side
// ---------------------------------------------------------------------------
interface updown_sweep_controller_if #(
    parameter int WIDTH  = 4,
    parameter int PASS_W = 4
);
    logic              start;
    logic              abort;
    logic              pause;
    logic [WIDTH-1:0]  lo;
    logic [WIDTH-1:0]  hi;
    logic [PASS_W-1:0] passes;

    logic [WIDTH-1:0]  count;
    logic              direction;
    logic              busy;
    logic              done;
    logic              err;
    logic [PASS_W-1:0] passes_left;
    logic [1:0]        dbg_state;

    modport master (
        output start, abort, pause, lo, hi, passes,
        input  count, direction, busy, done, err, passes_left, dbg_state
    );

    modport slave (
        input  start, abort, pause, lo, hi, passes,
        output count, direction, busy, done, err, passes_left, dbg_state
    );
endinterface

// File: rtl/updown_sweep_controller.sv
// ---------------------------------------------------------------------------
// updown_sweep_controller
//
// Owns a WIDTH-bit up/down counter and runs programmed triangle sweeps
// lo -> hi -> lo for a number of passes. Sweeps can be paused (everything
// freezes) and aborted (return to IDLE, counter values held).
//
// Ports
//   clk   rising-edge clock
//   rst   asynchronous, active-low reset
//   bus   updown_sweep_controller_if.slave
//           in : start, abort, pause, lo, hi, passes
//           out: count, direction, busy, done, err, passes_left, dbg_state
//
// All outputs come straight from flops. The FSM uses one register process
// and one combinational next-state process. Every registered value has a
// matching *_d next value that is computed in always_comb.
// ---------------------------------------------------------------------------
module updown_sweep_controller #(
    parameter int WIDTH  = 4,
    parameter int PASS_W = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    updown_sweep_controller_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UP   = 2'd1,
        S_DOWN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  count_q, count_d;
    logic              dir_q, dir_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [PASS_W-1:0] left_q, left_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic [WIDTH-1:0]  hi_q, hi_d;

    // A start is only meaningful for a non-empty range and a non-zero pass
    // count. Both checks use the live inputs because nothing is latched yet.
    logic start_bad;
    assign start_bad = (bus.lo >= bus.hi) || (bus.passes == '0);

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        dir_d   = dir_q;
        busy_d  = busy_q;
        left_d  = left_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // abort in IDLE simply masks start.
                if (bus.start && !bus.abort) begin
                    if (start_bad) begin
                        err_d = 1'b1;
                    end else begin
                        lo_d    = bus.lo;
                        hi_d    = bus.hi;
                        left_d  = bus.passes;
                        count_d = bus.lo;
                        dir_d   = 1'b1;
                        busy_d  = 1'b1;
                        state_d = S_UP;
                    end
                end
            end

            S_UP: begin
                if (bus.abort) begin
                    // Abort wins over pause; count/direction/passes_left hold.
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (!bus.pause) begin
                    if (count_q < hi_q) begin
                        count_d = count_q + 1'b1;
                    end else begin
                        // count == hi: the turn-around costs no extra cycle,
                        // the counter steps straight to hi-1.
                        count_d = count_q - 1'b1;
                        dir_d   = 1'b0;
                        state_d = S_DOWN;
                    end
                end
            end

            S_DOWN: begin
                if (bus.abort) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (!bus.pause) begin
                    if (count_q > lo_q) begin
                        count_d = count_q - 1'b1;
                    end else if (left_q == PASS_W'(1)) begin
                        // Last pass finished: count stays at lo and
                        // direction stays down.
                        left_d  = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        // More passes to go: lo is shared between passes, so
                        // the count turns straight back up.
                        left_d  = left_q - 1'b1;
                        count_d = count_q + 1'b1;
                        dir_d   = 1'b1;
                        state_d = S_UP;
                    end
                end
            end

            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            dir_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            left_q  <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            left_q  <= left_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

    assign bus.count       = count_q;
    assign bus.direction   = dir_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.passes_left = left_q;
    assign bus.dbg_state   = state_q;

    // ------------------------------------------------------------------
    // Structural invariants
    // ------------------------------------------------------------------
    // While sweeping, the counter stays inside the latched window.
    a_count_in_range: assert property (@(posedge clk) disable iff (!rst)
        busy_q |-> (count_q >= lo_q && count_q <= hi_q));

    // done is a single-cycle pulse and never overlaps busy.
    a_done_pulse: assert property (@(posedge clk) disable iff (!rst)
        done_q |=> !done_q);
    a_done_not_busy: assert property (@(posedge clk) disable iff (!rst)
        done_q |-> !busy_q);

    // busy tracks "FSM not in IDLE".
    a_busy_state: assert property (@(posedge clk) disable iff (!rst)
        busy_q == (state_q != S_IDLE));

endmodule

// File: tb/tb_updown_sweep_controller.sv
module tb_updown_sweep_controller;

    localparam int WIDTH  = 4;
    localparam int PASS_W = 4;
    localparam int ENT_W  = 1 + PASS_W + WIDTH;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    updown_sweep_controller_if #(.WIDTH(WIDTH), .PASS_W(PASS_W)) bus ();

    updown_sweep_controller #(.WIDTH(WIDTH), .PASS_W(PASS_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ------------------------------------------------------------------
    // Scoreboard / reference model
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;
    int busy_cycles = 0;

    // Remaining expected {direction, passes_left, count} of the current sweep,
    // one entry per busy cycle still to come.
    logic [ENT_W-1:0] exp_q[$];

    logic              m_busy;
    logic              m_done;
    logic              m_err;
    logic              m_dir;
    logic [WIDTH-1:0]  m_count;
    logic [PASS_W-1:0] m_left;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_busy  = 1'b0;
        m_done  = 1'b0;
        m_err   = 1'b0;
        m_dir   = 1'b1;
        m_count = '0;
        m_left  = '0;
    endtask

    // The whole triangle is written out as a list: lo, then for every pass
    // the climb to hi and the descent back to lo.
    task automatic build_sweep(input int l, input int h, input int n);
        exp_q.delete();
        exp_q.push_back({1'b1, PASS_W'(n), WIDTH'(l)});
        for (int p = n; p >= 1; p--) begin
            for (int c = l + 1; c <= h; c++)
                exp_q.push_back({1'b1, PASS_W'(p), WIDTH'(c)});
            for (int c = h - 1; c >= l; c--)
                exp_q.push_back({1'b0, PASS_W'(p), WIDTH'(c)});
        end
    endtask

    task automatic model_pop();
        {m_dir, m_left, m_count} = exp_q.pop_front();
    endtask

    task automatic model_edge(input logic s, input logic a, input logic p,
                              input int l, input int h, input int n);
        m_done = 1'b0;
        m_err  = 1'b0;
        if (!m_busy) begin
            if (s && !a) begin
                if (l >= h || n == 0) begin
                    m_err = 1'b1;
                end else begin
                    build_sweep(l, h, n);
                    model_pop();
                    m_busy = 1'b1;
                end
            end
        end else if (a) begin
            m_busy = 1'b0;
        end else if (!p) begin
            if (exp_q.size() == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                m_left = '0;
            end else begin
                model_pop();
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".count"},       32'(bus.count),       32'(m_count));
        check({tag, ".direction"},   32'(bus.direction),   32'(m_dir));
        check({tag, ".busy"},        32'(bus.busy),        32'(m_busy));
        check({tag, ".done"},        32'(bus.done),        32'(m_done));
        check({tag, ".err"},         32'(bus.err),         32'(m_err));
        check({tag, ".passes_left"}, 32'(bus.passes_left), 32'(m_left));
    endtask

    // ------------------------------------------------------------------
    // Driver: one clock cycle, inputs set on the falling edge, outputs
    // compared 1 time unit after the rising edge.
    // ------------------------------------------------------------------
    task automatic step(input string tag, input logic s, input logic a,
                        input logic p, input int l, input int h, input int n);
        @(negedge clk);
        bus.start  = s;
        bus.abort  = a;
        bus.pause  = p;
        bus.lo     = WIDTH'(l);
        bus.hi     = WIDTH'(h);
        bus.passes = PASS_W'(n);
        if (!rst) model_reset();
        else      model_edge(s, a, p, l, h, n);
        @(posedge clk);
        #1;
        if (bus.busy) busy_cycles++;
        compare_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    // Run with quiet inputs until done is seen; an expired budget is a failure.
    task automatic run_to_done(input string tag, input int budget);
        int k;
        k = 0;
        while (!bus.done && k < budget) begin
            idle(tag);
            k++;
        end
        if (!bus.done) check({tag, ".timeout"}, 0, 1);
    endtask

    task automatic run_to_count(input string tag, input int c, input logic d,
                                input int budget);
        int k;
        k = 0;
        while (!(bus.count == WIDTH'(c) && bus.direction == d) && k < budget) begin
            idle(tag);
            k++;
        end
        if (!(bus.count == WIDTH'(c) && bus.direction == d))
            check({tag, ".timeout"}, 0, 1);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        bus.start  = 1'b0;
        bus.abort  = 1'b0;
        bus.pause  = 1'b0;
        bus.lo     = '0;
        bus.hi     = '0;
        bus.passes = '0;
        rst = 1'b0;
        model_reset();

        // Reset held with the clock running, even with start requested.
        for (int i = 0; i < 3; i++) step("reset", 1'b1, 1'b0, 1'b0, 1, 5, 1);
        #2 rst = 1'b1;
        for (int i = 0; i < 3; i++) idle("post_reset");

        // Single pass 2..4..2.
        busy_cycles = 0;
        step("single_start", 1'b1, 1'b0, 1'b0, 2, 4, 1);
        check("single_first_count", 32'(bus.count), 2);
        run_to_done("single", 20);
        check("single_busy_cycles", busy_cycles, 5);
        check("single_done_count", 32'(bus.count), 2);
        idle("single_after");

        // Two passes over the full range.
        busy_cycles = 0;
        step("multi_start", 1'b1, 1'b0, 1'b0, 0, 15, 2);
        run_to_done("multi", 100);
        check("multi_busy_cycles", busy_cycles, 61);

        // Back-to-back start on the done cycle.
        busy_cycles = 0;
        step("b2b_start", 1'b1, 1'b0, 1'b0, 3, 5, 1);
        run_to_done("b2b", 20);
        check("b2b_busy_cycles", busy_cycles, 5);

        // Rejected starts.
        step("rej_equal", 1'b1, 1'b0, 1'b0, 5, 5, 1);
        check("rej_equal_err", 32'(bus.err), 1);
        check("rej_equal_busy", 32'(bus.busy), 0);
        idle("rej_gap");
        step("rej_zero_passes", 1'b1, 1'b0, 1'b0, 1, 9, 0);
        check("rej_zero_err", 32'(bus.err), 1);
        idle("rej_gap2");
        step("abort_masks_start", 1'b1, 1'b1, 1'b0, 1, 9, 1);

        // Start while busy is ignored.
        step("busy_start", 1'b1, 1'b0, 1'b0, 1, 3, 1);
        step("busy_restart", 1'b1, 1'b0, 1'b0, 9, 3, 0);
        check("busy_restart_err", 32'(bus.err), 0);
        run_to_done("busy_run", 20);

        // Pause for 3 cycles at count=3 going up: done 3 cycles later.
        busy_cycles = 0;
        step("pause_start", 1'b1, 1'b0, 1'b0, 0, 5, 1);
        run_to_count("pause_seek", 3, 1'b1, 20);
        for (int i = 0; i < 3; i++) step("pause_hold", 1'b0, 1'b0, 1'b1, 0, 0, 0);
        check("pause_count", 32'(bus.count), 3);
        run_to_done("pause_run", 30);
        check("pause_busy_cycles", busy_cycles, 14);

        // Abort (with pause) at count=4 going down.
        step("abort_start", 1'b1, 1'b0, 1'b0, 2, 6, 1);
        run_to_count("abort_seek", 4, 1'b0, 20);
        step("abort", 1'b0, 1'b1, 1'b1, 0, 0, 0);
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_done", 32'(bus.done), 0);
        check("abort_count", 32'(bus.count), 4);
        for (int i = 0; i < 3; i++) idle("abort_after");

        // Asynchronous reset between edges.
        step("areset_start", 1'b1, 1'b0, 1'b0, 0, 5, 2);
        run_to_count("areset_seek", 3, 1'b1, 20);
        #2 rst = 1'b0;
        #1;
        model_reset();
        compare_all("areset_immediate");
        step("areset_hold", 1'b0, 1'b0, 1'b0, 0, 0, 0);
        #2 rst = 1'b1;
        for (int i = 0; i < 3; i++) idle("areset_idle");

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            step("random",
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 59) == 0,
                 $urandom_range(0, 7) == 0,
                 int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/updown_sweep_controller.md
# updown_sweep_controller

Sequencer for the 4-bit up/down counter datapath. It owns the counter register and the direction control, and runs programmed triangle sweeps lo→hi→lo for a given number of passes under a start/busy/done handshake. Sweeps can be paused and aborted. It sits between a host or test controller and any logic that consumes the sweeping count value.

## Interface
- WIDTH, 4, width of count, lo and hi
- PASS_W, 4, width of passes and passes_left
- clk  in  1  rising-edge clock; the only clock
- rst  in  1  asynchronous, active-low reset (0 = reset asserted)
- start  in  1  request a sweep; sampled only in IDLE
- abort  in  1  synchronous cancel; highest priority
- pause  in  1  freezes all state while busy
- lo  in  WIDTH  lower bound, latched on accepted start
- hi  in  WIDTH  upper bound, latched on accepted start
- passes  in  PASS_W  number of full lo→hi→lo passes, latched on accepted start
- count  out  WIDTH  counter value
- direction  out  1  1 = counting up, 0 = counting down
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse when the sweep completes normally
- err  out  1  one-cycle pulse when a start is rejected
- passes_left  out  PASS_W  passes remaining, including the current pass

## Operation
- States: IDLE, UP, DOWN. All outputs are registered.
- Reset (rst=0, asynchronous): state=IDLE, count=0, direction=1, busy=0, done=0, err=0, passes_left=0. Internal lo/hi latches clear to 0.
- done and err default to 0 every cycle unless set below.
- IDLE, start=1, abort=0:
  - If lo>=hi or passes==0: err=1 for one cycle. All other state is unchanged.
  - Otherwise: latch lo, hi and passes; set count=lo, direction=1, passes_left=passes, busy=1; go to UP.
- IDLE with abort=1: start is ignored and nothing changes.
- UP (no pause/abort):
  - If count<hi: count+1.
  - If count==hi: count-1, direction=0, go to DOWN.
- DOWN (no pause/abort):
  - If count>lo: count-1.
  - If count==lo and passes_left==1: passes_left=0, busy=0, done=1, go to IDLE. count holds lo and direction holds 0.
  - If count==lo and passes_left>1: passes_left-1, count+1, direction=1, go to UP.
- pause=1 while busy (abort=0): count, direction, state and passes_left all hold. A completion that is due is deferred, not dropped.
- abort=1 while busy: go to IDLE, busy=0, done=0. count, direction and passes_left hold their current values. Abort beats pause.
- start while busy is ignored; no err pulse.
- lo/hi/passes inputs changing while busy have no effect.
- count never leaves [lo_latched, hi_latched] during a sweep, so no wrap-around can occur.

## Timing
- Start latency: count=lo and busy=1 are visible the cycle after the edge that samples start.
- A sweep with P passes keeps busy high for exactly P·2·(hi−lo)+1 cycles, plus the number of paused cycles.
- done rises in the same cycle that busy falls and lasts exactly one cycle.
- A new start can be accepted on the first cycle busy=0, i.e. on the cycle done=1.
- err is asserted the cycle after the rejected start and lasts one cycle.
- Reset asserted mid-sweep forces all outputs to their reset values immediately, without waiting for a clock edge. After release, the block idles until the next start.

## Test plan
- Reset behaviour: hold rst=0 with clk running → count=0, direction=1, busy=0, done=0, err=0, passes_left=0. After release the block stays idle.
- Single pass: lo=2, hi=4, passes=1, pulse start → count sequence 2,3,4,3,2 with direction 1,1,1,0,0. busy is high for 5 cycles, then done=1 for one cycle with count=2.
- Multi-pass: lo=0, hi=15, passes=2 → full 0..15..0..15..0 sweep with no wrap. passes_left goes 2→1 at the first return to 0. busy is high for 61 cycles.
- Rejects: start with lo=5, hi=5 → err pulse, busy stays 0. start with passes=0 → err pulse. start while busy → ignored, no err.
- Pause/abort: pause for 3 cycles at count=3 (UP) → count holds 3, and done arrives 3 cycles later than without the pause. Abort at count=4 in DOWN with pause=1 → IDLE, busy=0, no done, count holds 4.
- Async reset mid-sweep: drive rst=0 between clock edges at count=3 → outputs return to reset values before the next edge.
